// File: rtl/debounce_pkg.sv
// debounce_pkg: constants and types shared by the input debouncer.
//   CICLOS_ESTABLES_DEF : default number of stable cycles before a bit flips
//   SYNC_STAGES_DEF     : default synchronizer depth (legal 2..4)
//   estado_t            : per-bit debouncer state {ESTABLE, CONTANDO}
package debounce_pkg;

  localparam int CICLOS_ESTABLES_DEF = 50000;
  localparam int SYNC_STAGES_DEF     = 2;

  typedef enum logic {
    ESTABLE  = 1'b0,
    CONTANDO = 1'b1
  } estado_t;

endpackage

// File: rtl/debounce_entradas_if.sv
// debounce_entradas_if: bus between the raw-input source and the debouncer.
//   iA      : raw asynchronous inputs (switches/buttons)
//   oA      : debounced, synchronized inputs
//   oCambio : one-cycle pulse per bit when its oA bit flips
//   oValido : high once the post-reset settle window has elapsed
// Modports: master = input source / consumer side, slave = debouncer side.
interface debounce_entradas_if #(
  parameter int ANCHO = 3
);

  logic [ANCHO-1:0] iA;
  logic [ANCHO-1:0] oA;
  logic [ANCHO-1:0] oCambio;
  logic             oValido;

  modport master (
    output iA,
    input  oA,
    input  oCambio,
    input  oValido
  );

  modport slave (
    input  iA,
    output oA,
    output oCambio,
    output oValido
  );

endinterface

// File: rtl/antirrebote_bit.sv
// antirrebote_bit: one-bit synchronizer + debouncer.
//   iClk    : clock, rising edge
//   iReset  : synchronous reset, active-high
//   iA      : raw asynchronous input bit
//   oA      : debounced bit, flips after CICLOS_ESTABLES consecutive
//             cycles of the synchronized input differing from it
//   oCambio : one-cycle pulse on the cycle oA flips (ungated)
// Optional macro DEBOUNCE_ENTRADAS_INVERTIR_EN: invert iA ahead of the
// first synchronizer flop (active-low buttons).
module antirrebote_bit
  import debounce_pkg::*;
#(
  parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
  parameter int CICLOS_ESTABLES = CICLOS_ESTABLES_DEF
) (
  input  logic iClk,
  input  logic iReset,
  input  logic iA,
  output logic oA,
  output logic oCambio
);

  localparam int CNT_W = $clog2(CICLOS_ESTABLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CICLOS_ESTABLES - 1);

  logic                   a_in;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;

  estado_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic           a_d;
  logic           cambio_d;

`ifdef DEBOUNCE_ENTRADAS_INVERTIR_EN
  assign a_in = ~iA;
`else
  assign a_in = iA;
`endif

  assign s = sync_q[SYNC_STAGES-1];

  // Counter starts on the first mismatching cycle, so the flip lands
  // exactly CICLOS_ESTABLES edges after the synchronized value changes.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // leaves a variable unassigned and infers a latch.
    state_d  = state_q;
    cnt_d    = '0;
    a_d      = oA;
    cambio_d = 1'b0;
    unique case (state_q)
      ESTABLE: begin
        if (s != oA) begin
          state_d = CONTANDO;
          cnt_d   = cnt_q + 1'b1;
        end
      end
      CONTANDO: begin
        if (s == oA) begin
          state_d = ESTABLE;               // glitch rejected
        end else if (cnt_q == CNT_LAST) begin
          state_d  = ESTABLE;              // level accepted
          a_d      = s;
          cambio_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ESTABLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values, which the shift chain depends on.
  always_ff @(posedge iClk) begin
    if (iReset) begin
      sync_q  <= '0;
      state_q <= ESTABLE;
      cnt_q   <= '0;
      oA      <= 1'b0;
      oCambio <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], a_in};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      oA      <= a_d;
      oCambio <= cambio_d;
    end
  end

endmodule

// File: rtl/debounce_entradas.sv
// debounce_entradas: synchronizes and debounces ANCHO raw input bits.
//   iClk   : clock, rising edge
//   iReset : synchronous reset, active-high
//   bus    : debounce_entradas_if.slave (iA in; oA, oCambio, oValido out)
// oValido rises SYNC_STAGES + CICLOS_ESTABLES cycles after reset release;
// until then oCambio is held at 0 so power-up settling produces no edges.
// Optional macro DEBOUNCE_ENTRADAS_INVERTIR_EN (see antirrebote_bit).
module debounce_entradas
  import debounce_pkg::*;
#(
  parameter int ANCHO           = 3,
  parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
  parameter int CICLOS_ESTABLES = CICLOS_ESTABLES_DEF
) (
  input  logic                iClk,
  input  logic                iReset,
  debounce_entradas_if.slave  bus
);

  localparam int SETTLE_MAX = SYNC_STAGES + CICLOS_ESTABLES - 1;
  localparam int SETTLE_W   = $clog2(SETTLE_MAX + 1);

  logic [ANCHO-1:0]    cambio_raw;
  logic [SETTLE_W-1:0] settle_q;
  logic                valido_q;

  for (genvar i = 0; i < ANCHO; i++) begin : gen_bit
    antirrebote_bit #(
      .SYNC_STAGES     (SYNC_STAGES),
      .CICLOS_ESTABLES (CICLOS_ESTABLES)
    ) u_bit (
      .iClk    (iClk),
      .iReset  (iReset),
      .iA      (bus.iA[i]),
      .oA      (bus.oA[i]),
      .oCambio (cambio_raw[i])
    );
  end

  // Settle counter stops once oValido is set and stays until next reset.
  always_ff @(posedge iClk) begin
    if (iReset) begin
      settle_q <= '0;
      valido_q <= 1'b0;
    end else if (!valido_q) begin
      if (settle_q == SETTLE_W'(SETTLE_MAX)) begin
        valido_q <= 1'b1;
      end else begin
        settle_q <= settle_q + 1'b1;
      end
    end
  end

  // Both operands are flop outputs, so the gated pulse stays glitch-free
  // and has no path from iA.
  assign bus.oCambio = cambio_raw & {ANCHO{valido_q}};
  assign bus.oValido = valido_q;

endmodule

// File: tb/tb_debounce_entradas.sv
// tb_debounce_entradas: directed self-checking bench for debounce_entradas
// with CICLOS_ESTABLES = 4, SYNC_STAGES = 2. Inputs are driven 1 time unit
// after a rising edge; outputs are checked at that same point, i.e. after
// the edge that produced them. Drive values are "logical": when
// DEBOUNCE_ENTRADAS_INVERTIR_EN is defined they are inverted before
// reaching iA, so the expected oA values are identical in both builds.
module tb_debounce_entradas;

  localparam int ANCHO = 3;

  logic iClk = 1'b0;
  logic iReset;

  int total = 0;
  int bad   = 0;

  debounce_entradas_if #(.ANCHO(ANCHO)) bus ();

  debounce_entradas #(
    .ANCHO           (ANCHO),
    .SYNC_STAGES     (2),
    .CICLOS_ESTABLES (4)
  ) dut (
    .iClk   (iClk),
    .iReset (iReset),
    .bus    (bus)
  );

  always #5 iClk = ~iClk;

  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  task automatic drive(input logic [ANCHO-1:0] v);
`ifdef DEBOUNCE_ENTRADAS_INVERTIR_EN
    bus.iA = ~v;
`else
    bus.iA = v;
`endif
  endtask

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp)
      else begin
        bad++;
        $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  task automatic check_out(input string tag, input logic [ANCHO-1:0] a,
                           input logic [ANCHO-1:0] c, input logic v);
    check({tag, ".oA"},      32'(bus.oA),      32'(a));
    check({tag, ".oCambio"}, 32'(bus.oCambio), 32'(c));
    check({tag, ".oValido"}, 32'(bus.oValido), 32'(v));
  endtask

  initial begin
    // Reset and settle.
    iReset = 1'b1;
    drive(3'b000);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_out("reset", 3'b000, 3'b000, 1'b0);
    end
    iReset = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      tick();
      check_out("settle", 3'b000, 3'b000, i >= 6);
    end

    // Clean change 000 -> 101: flip on the 6th edge after the set.
    drive(3'b101);
    for (int i = 1; i <= 7; i++) begin
      tick();
      check_out("clean", (i >= 6) ? 3'b101 : 3'b000,
                (i == 6) ? 3'b101 : 3'b000, 1'b1);
    end

    // Glitch on bit 1: high for 3 sampled edges, then low again.
    drive(3'b111);
    for (int i = 0; i < 3; i++) tick();
    drive(3'b101);
    for (int i = 0; i < 8; i++) begin
      tick();
      check_out("glitch", 3'b101, 3'b000, 1'b1);
    end
    check("glitch.cnt1", 32'(dut.gen_bit[1].u_bit.cnt_q), 32'd0);

    // Falling change 101 -> 000.
    drive(3'b000);
    for (int i = 1; i <= 7; i++) begin
      tick();
      check_out("fall", (i >= 6) ? 3'b000 : 3'b101,
                (i == 6) ? 3'b101 : 3'b000, 1'b1);
    end

    // Bounce on bit 0: 1,0,1,0 on consecutive edges, then hold 1.
    drive(3'b001); tick(); check_out("bounce", 3'b000, 3'b000, 1'b1);
    drive(3'b000); tick(); check_out("bounce", 3'b000, 3'b000, 1'b1);
    drive(3'b001); tick(); check_out("bounce", 3'b000, 3'b000, 1'b1);
    drive(3'b000); tick(); check_out("bounce", 3'b000, 3'b000, 1'b1);
    drive(3'b001);
    for (int i = 1; i <= 8; i++) begin
      tick();
      check_out("settle0", (i >= 6) ? 3'b001 : 3'b000,
                (i == 6) ? 3'b001 : 3'b000, 1'b1);
    end

    // Reset mid-count: 111 applied, reset 2 edges later.
    drive(3'b111);
    tick(); tick();
    check_out("precount", 3'b001, 3'b000, 1'b1);
    iReset = 1'b1;
    tick();
    check_out("midreset", 3'b000, 3'b000, 1'b0);
    tick();
    check_out("midreset", 3'b000, 3'b000, 1'b0);
    iReset = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      tick();
      check_out("rerun", (i >= 6) ? 3'b111 : 3'b000,
                (i == 6) ? 3'b111 : 3'b000, i >= 6);
    end

`ifdef DEBOUNCE_ENTRADAS_INVERTIR_EN
    // Raw 111 (all buttons released) from reset reads as 000.
    iReset = 1'b1;
    bus.iA = 3'b111;
    tick(); tick();
    iReset = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      tick();
      check_out("inv.idle", 3'b000, 3'b000, i >= 6);
    end
    bus.iA = 3'b110;
    for (int i = 1; i <= 7; i++) begin
      tick();
      check_out("inv.press", (i >= 6) ? 3'b001 : 3'b000,
                (i == 6) ? 3'b001 : 3'b000, 1'b1);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/debounce_entradas.md
Name: debounce_entradas

Overview:
- Input-conditioning stage directly upstream of the 3-input gate top-level.
- Takes raw, asynchronous switch/button levels and synchronizes each bit into iClk.
- Debounces each bit and drives the clean 3-bit bus that feeds the gate's iA input.
- Also flags per-bit changes so downstream logic can detect edges without its own registers.

Parameters:
- ANCHO, 3, number of independent input bits.
- SYNC_STAGES, 2, synchronizer flop depth per bit; legal range 2..4.
- CICLOS_ESTABLES, 50000, consecutive cycles a synchronized bit must differ from its output before the output flips; must be ≥2.

Ports:
- iClk  input  1  system clock; all logic on rising edge.
- iReset  input  1  synchronous reset, active-high.
- iA  input  ANCHO  raw asynchronous inputs (switches/buttons).
- oA  output  ANCHO  debounced, synchronized inputs; connects to the gate block's iA.
- oCambio  output  ANCHO  one-cycle pulse per bit on the cycle its oA bit flips.
- oValido  output  1  high once the initial settle window after reset has elapsed.

Behaviour:
- Single clock domain on iClk. Reset is synchronous and active-high on iReset; it is sampled only at iClk rising edges.
- Reset values: synchronizer flops 0; counters 0; oA = 0; oCambio = 0; oValido = 0.
- Reset asserted mid-count discards all progress: the next cycle shows reset values, with no oCambio pulse.
- Each bit passes through SYNC_STAGES flops. The last stage is s[i].
- Per-bit state machine:
  - ESTABLE: s[i] == oA[i]; counter held at 0.
  - CONTANDO: s[i] != oA[i]; counter increments by 1 each cycle.
  - ESTABLE → CONTANDO: on the first cycle s[i] != oA[i].
  - CONTANDO → ESTABLE (glitch rejected): s[i] returns equal to oA[i] before the count completes. Counter clears to 0 on the same edge; oA[i] is unchanged; no oCambio.
  - CONTANDO → ESTABLE (accepted): counter == CICLOS_ESTABLES-1 and s[i] still != oA[i]. On that edge oA[i] <= s[i], counter <= 0, and oCambio[i] = 1 for exactly the next cycle.
- Latency: a clean level change on iA[i], first sampled at edge k, appears on oA[i] after edge k + SYNC_STAGES + CICLOS_ESTABLES - 1.
- Counter width is $clog2(CICLOS_ESTABLES). The counter never exceeds CICLOS_ESTABLES-1, so it never wraps.
- Bits are fully independent. Simultaneous changes on several bits flip in the same cycle and pulse their oCambio bits together.
- A continuously toggling input, with period < 2*CICLOS_ESTABLES cycles, never changes oA.
- oValido: a separate settle counter starts from reset release and runs SYNC_STAGES + CICLOS_ESTABLES cycles, then oValido = 1 until the next reset.
- While oValido = 0, oA still updates normally but oCambio is forced to 0. This suppresses spurious power-up edges.
- No combinational path from iA to any output. All outputs are registered.

Optional Feature:
- Macro: DEBOUNCE_ENTRADAS_INVERTIR_EN.
- Defined: iA is inverted before the first synchronizer flop, for active-low buttons. Reset values are unchanged (oA = 0), so held-released buttons read 0.
- Not defined: iA is used as-is; no inverter is present in the netlist.

Decomposition:
- Shared package debounce_pkg holds:
  - default constants CICLOS_ESTABLES_DEF = 50000 and SYNC_STAGES_DEF = 2;
  - a typedef for the two-state enum {ESTABLE, CONTANDO}.
- Sub-module antirrebote_bit contains one bit's synchronizer, counter and state machine, with ports iClk, iReset, iA (1 bit), oA, oCambio.
- The top level instantiates antirrebote_bit ANCHO times in a generate loop and adds the oValido settle counter plus the oCambio gating.

Test Plan:
All scenarios use CICLOS_ESTABLES = 4, SYNC_STAGES = 2.
- Reset and settle: hold iReset 3 cycles, iA = 3'b000, then release → oA = 000, oCambio = 000 throughout; oValido rises exactly 6 cycles after release.
- Clean change: after settle, iA = 3'b101 at edge k → oA = 101 after edge k+5; oCambio = 101 for exactly that one cycle; then 000.
- Glitch rejection: iA[1] high for 3 cycles, then low → oA[1] stays 0; oCambio[1] stays 0; counter observed back at 0.
- Bounce then settle: iA[0] toggles 1,0,1,0,1 on consecutive cycles, then holds 1 → oA[0] rises exactly 5 cycles after the final 0→1 sample; a single oCambio pulse.
- Reset mid-count: iA = 3'b111 held; iReset asserted 2 cycles after the change → oA = 000, no oCambio; after release, oA = 111 only after a full 6-cycle window.
- With DEBOUNCE_ENTRADAS_INVERTIR_EN defined: iA = 3'b111 held from reset → oA stays 000; iA = 3'b110 → oA = 001 after 5 cycles.
